pio_access_arbiter: RTL and testbench
=====================================

Name: pio_access_arbiter

Overview:
- Shares one 8-bit bidirectional PIO slave register port (data/dir/set/clear) among NUM_REQ on-chip requesters, e.g. CPU shim, bit-bang engine, debug port.
- Round-robin grant. Issues exactly one single-cycle PIO access per grant.
- Returns read data to the granted requester, accounting for the PIO's registered (1-cycle) readdata.
- Sits between the requesters and the PIO's s1 slave inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, PIO data bus width.
- ADDR_W, 3, PIO register address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request pending; held until req_ready.
- req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_address  in  NUM_REQ*ADDR_W  packed register address; requester i at [i*ADDR_W +: ADDR_W].
- req_writedata  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- rsp_readdata  out  DATA_W  shared; valid only with rsp_valid.
- pio_address  out  ADDR_W  to PIO address.
- pio_chipselect  out  1  to PIO chipselect.
- pio_write_n  out  1  to PIO write_n (active low).
- pio_writedata  out  DATA_W  to PIO writedata.
- pio_readdata  in  DATA_W  from PIO readdata (registered in PIO, updates every clock).

Behaviour:
- One clock (clk). Synchronous, active-high reset (reset); all state updates on posedge clk.
- Reset values:
  - state=IDLE, rr_ptr=0, grant=0.
  - req_ready=0, rsp_valid=0, rsp_readdata=0.
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req_valid, pick the first set index at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g] pulses in the accept cycle A; the request fields are latched.
  - rr_ptr <= (g+1) mod NUM_REQ. Go to ISSUE.
  - With no req_valid: stay in IDLE, no outputs change.
- ISSUE (cycle A+1):
  - pio_chipselect=1, pio_address/pio_write_n/pio_writedata from the latch, for exactly one cycle.
  - Write: go to RESP. Read: go to CAPTURE.
- CAPTURE (A+2): pio_readdata now reflects the ISSUE address; register it into rsp_readdata. Go to RESP.
- RESP:
  - rsp_valid[g]=1 for one cycle, then IDLE.
  - Write completes at A+2 with rsp_readdata unchanged. Read completes at A+3.
- Outside ISSUE, the PIO bus is held idle: chipselect=0, write_n=1, address/writedata=0.
- New arbitration only in IDLE, so the minimum request spacing is 3 cycles (write) or 4 cycles (read).
- Addresses pass through unchecked. Illegal PIO addresses 2, 3, 6, 7 are still issued.
- req_valid dropping before grant is tolerated; nothing is issued.
- Changes to req_* after accept are ignored.
- Reset asserted in any state: the FSM returns to IDLE next edge; an in-flight access is abandoned with no rsp_valid.
- An ISSUE cycle coincident with reset must not drive chipselect after the reset edge.

Optional Feature:
- Macro: PIO_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock [NUM_REQ].
  - A request accepted with req_lock=1 sets locked=1 and owner=g.
  - While locked, IDLE grants only the owner; other requesters wait.
  - The owner's next accepted request with req_lock=0 clears the lock at its RESP.
  - Reset clears the lock.
  - This enables atomic read-modify-write of the dir register.
- When undefined: port absent, pure round robin.

Decomposition:
- Package pio_arb_pkg:
  - state enum (IDLE/ISSUE/CAPTURE/RESP).
  - localparams PIO_REG_DATA=0, PIO_REG_DIR=1, PIO_REG_SET=4, PIO_REG_CLR=5.
  - Default widths.
- Sub-module pio_rr_pick: combinational round-robin index finder. Inputs: valid vector, rr_ptr, optional mask. Outputs: one-hot grant and any_valid.

Test Plan:
- Requester 1 writes addr 1, data 0xFF at A -> req_ready[1] at A; chipselect=1, write_n=0, addr=1, wd=0xFF at A+1 only; rsp_valid[1] at A+2.
- Requester 2 reads addr 0, PIO model returns 0xA5 one cycle after ISSUE -> rsp_valid[2] at A+3, rsp_readdata=0x000000A5.
- All 4 requesters valid continuously, rr_ptr=0 -> grant order 0,1,2,3,0; each grant spaced ≥3 cycles; no starvation over 20 grants.
- Reset asserted in the ISSUE cycle of a read -> next cycle chipselect=0, no rsp_valid, state IDLE, rr_ptr=0.
- Requester 0 writes addr 4 (set) 0x0F then addr 5 (clear) 0x03; PIO model data_out starts 0 -> ends 0x0C; two distinct chipselect pulses.
- PIO_ARB_LOCK_EN: req 3 locked read of dir, req 0 valid meanwhile -> req 0 not granted until req 3's unlocked write RESP completes.

Source files
------------

// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO access arbiter: FSM state encoding,
// PIO register map and default widths.
package pio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } arb_state_t;

   localparam logic [2:0] PIO_REG_DATA = 3'd0;
   localparam logic [2:0] PIO_REG_DIR  = 3'd1;
   localparam logic [2:0] PIO_REG_SET  = 3'd4;
   localparam logic [2:0] PIO_REG_CLR  = 3'd5;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_ADDR_W  = 3;

endpackage

// File: rtl/pio_rr_pick.sv
// Combinational round-robin finder: first eligible requester at or after
// rr_ptr, wrapping modulo NUM_REQ. Returns a one-hot grant and any_valid.
module pio_rr_pick
   import pio_arb_pkg::*;
#(
   parameter int  NUM_REQ = DEF_NUM_REQ,
   localparam int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [PTR_W-1:0]   rr_ptr,
   input  logic [NUM_REQ-1:0] mask,
   output logic [NUM_REQ-1:0] grant,
   output logic               any_valid
);

   logic [NUM_REQ-1:0] eligible;
   logic [PTR_W-1:0]   idx;

   assign eligible = valid & mask;

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!any_valid && eligible[idx]) begin
            grant[idx] = 1'b1;
            any_valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pio_access_arbiter.sv
// Round-robin arbiter sharing one PIO s1 slave among NUM_REQ requesters.
// Optional macro PIO_ARB_LOCK_EN adds req_lock for atomic owner sequences.
module pio_access_arbiter
   import pio_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_write,
`ifdef PIO_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        req_lock,
`endif
   input  logic [NUM_REQ*ADDR_W-1:0] req_address,
   input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_readdata,
   output logic [ADDR_W-1:0]         pio_address,
   output logic                      pio_chipselect,
   output logic                      pio_write_n,
   output logic [DATA_W-1:0]         pio_writedata,
   input  logic [DATA_W-1:0]         pio_readdata
);

   localparam int PTR_W = $clog2(NUM_REQ);

   arb_state_t          state, state_d;
   logic [PTR_W-1:0]    rr_ptr, rr_ptr_d;
   logic [NUM_REQ-1:0]  lat_grant, lat_grant_d;
   logic                lat_write, lat_write_d;
   logic [ADDR_W-1:0]   lat_addr, lat_addr_d;
   logic [DATA_W-1:0]   lat_wdata, lat_wdata_d;

   logic [NUM_REQ-1:0]  req_ready_d, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_readdata_d, wdata_d;
   logic [ADDR_W-1:0]   addr_d;
   logic                cs_d, write_n_d;

   logic [NUM_REQ-1:0]  pick_grant, pick_mask;
   logic                pick_any;
   logic [PTR_W-1:0]    g_idx;

`ifdef PIO_ARB_LOCK_EN
   logic                locked, locked_d;
   logic [PTR_W-1:0]    owner, owner_d;
   logic                lat_lock, lat_lock_d;

   // While locked only the owner is eligible; everyone else simply waits.
   assign pick_mask = locked ? (NUM_REQ'(1) << owner) : '1;
`else
   assign pick_mask = '1;
`endif

   pio_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr),
      .mask      (pick_mask),
      .grant     (pick_grant),
      .any_valid (pick_any)
   );

   always_comb begin
      g_idx = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (pick_grant[k]) g_idx = PTR_W'(k);
   end

   always_comb begin
      state_d        = state;
      rr_ptr_d       = rr_ptr;
      lat_grant_d    = lat_grant;
      lat_write_d    = lat_write;
      lat_addr_d     = lat_addr;
      lat_wdata_d    = lat_wdata;
      req_ready_d    = '0;
      rsp_valid_d    = '0;
      rsp_readdata_d = rsp_readdata;
      cs_d           = 1'b0;
      write_n_d      = 1'b1;
      addr_d         = '0;
      wdata_d        = '0;
`ifdef PIO_ARB_LOCK_EN
      locked_d       = locked;
      owner_d        = owner;
      lat_lock_d     = lat_lock;
`endif
      case (state)
         IDLE: begin
            if (pick_any) begin
               req_ready_d = pick_grant;
               lat_grant_d = pick_grant;
               lat_write_d = req_write[g_idx];
               lat_addr_d  = req_address[g_idx*ADDR_W +: ADDR_W];
               lat_wdata_d = req_writedata[g_idx*DATA_W +: DATA_W];
               rr_ptr_d    = PTR_W'((int'(g_idx) + 1) % NUM_REQ);
`ifdef PIO_ARB_LOCK_EN
               lat_lock_d  = req_lock[g_idx];
               if (req_lock[g_idx]) begin
                  locked_d = 1'b1;
                  owner_d  = g_idx;
               end
`endif
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            cs_d      = 1'b1;
            write_n_d = ~lat_write;
            addr_d    = lat_addr;
            wdata_d   = lat_wdata;
            state_d   = lat_write ? RESP : CAPTURE;
         end
         // Chipselect is on the bus now; the PIO's registered readdata
         // only reflects this address one cycle later, seen in RESP.
         CAPTURE: state_d = RESP;
         RESP: begin
            rsp_valid_d = lat_grant;
            if (!lat_write) rsp_readdata_d = pio_readdata;
`ifdef PIO_ARB_LOCK_EN
            if (!lat_lock) locked_d = 1'b0;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values,
   // consistent with the combinational next-state view above.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         lat_grant      <= '0;
         req_ready      <= '0;
         rsp_valid      <= '0;
         rsp_readdata   <= '0;
         pio_chipselect <= 1'b0;
         pio_write_n    <= 1'b1;
         pio_address    <= '0;
         pio_writedata  <= '0;
`ifdef PIO_ARB_LOCK_EN
         locked         <= 1'b0;
         owner          <= '0;
`endif
      end else begin
         state          <= state_d;
         rr_ptr         <= rr_ptr_d;
         lat_grant      <= lat_grant_d;
         req_ready      <= req_ready_d;
         rsp_valid      <= rsp_valid_d;
         rsp_readdata   <= rsp_readdata_d;
         pio_chipselect <= cs_d;
         pio_write_n    <= write_n_d;
         pio_address    <= addr_d;
         pio_writedata  <= wdata_d;
`ifdef PIO_ARB_LOCK_EN
         locked         <= locked_d;
         owner          <= owner_d;
`endif
      end
   end

   // NOTE: latched request fields are only consumed after a grant reloads
   // them, so they are left without reset.
   always_ff @(posedge clk) begin
      lat_write <= lat_write_d;
      lat_addr  <= lat_addr_d;
      lat_wdata <= lat_wdata_d;
`ifdef PIO_ARB_LOCK_EN
      lat_lock  <= lat_lock_d;
`endif
   end

endmodule

// File: tb/tb_pio_access_arbiter.sv
// Self-checking bench for pio_access_arbiter: PIO register model, response
// scoreboard and directed tests; lock test runs when PIO_ARB_LOCK_EN is set.
module tb_pio_access_arbiter;
   import pio_arb_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
   logic [N*AW-1:0] req_address;
   logic [N*DW-1:0] req_writedata;
   logic [DW-1:0]   rsp_readdata, pio_writedata, pio_readdata;
   logic [AW-1:0]   pio_address;
   logic            pio_chipselect, pio_write_n;
`ifdef PIO_ARB_LOCK_EN
   logic [N-1:0]    req_lock;
`endif

   always #5 clk = ~clk;

   pio_access_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
`ifdef PIO_ARB_LOCK_EN
      .req_lock       (req_lock),
`endif
      .req_address    (req_address),
      .req_writedata  (req_writedata),
      .rsp_valid      (rsp_valid),
      .rsp_readdata   (rsp_readdata),
      .pio_address    (pio_address),
      .pio_chipselect (pio_chipselect),
      .pio_write_n    (pio_write_n),
      .pio_writedata  (pio_writedata),
      .pio_readdata   (pio_readdata)
   );

   // PIO slave model: data/dir/set/clear with registered readdata.
   logic [DW-1:0] pio_data = '0;
   logic [DW-1:0] pio_dir  = '0;
   logic [DW-1:0] pio_pins = 32'h0000_00A5;

   always @(posedge clk) begin
      if (pio_chipselect && !pio_write_n) begin
         case (pio_address)
            PIO_REG_DATA: pio_data <= pio_writedata;
            PIO_REG_DIR:  pio_dir  <= pio_writedata;
            PIO_REG_SET:  pio_data <= pio_data | pio_writedata;
            PIO_REG_CLR:  pio_data <= pio_data & ~pio_writedata;
            default: ;
         endcase
      end
      case (pio_address)
         PIO_REG_DATA: pio_readdata <= pio_pins;
         PIO_REG_DIR:  pio_readdata <= pio_dir;
         default:      pio_readdata <= '0;
      endcase
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      int            idx;
      bit            rd;
      logic [DW-1:0] data;
   } sb_t;

   sb_t           sb[$];
   logic          rst_seen  = 1'b1;
   logic          cs_prev   = 1'b0;
   int            cs_pulses = 0;
   logic [DW-1:0] last_rd   = '0;

   always @(posedge clk) rst_seen <= reset;

   // Response monitor: pops the scoreboard on every completion pulse.
   always @(negedge clk) begin
      if (rst_seen) begin
         last_rd <= '0;
         cs_prev <= 1'b0;
      end else begin
         if (pio_chipselect) begin
            if (cs_prev) check("cs_single", 1, 0);
            cs_pulses <= cs_pulses + 1;
         end else begin
            check("bus_idle", {pio_write_n, pio_address, pio_writedata}, {1'b1, 3'b0, 32'b0});
         end
         cs_prev <= pio_chipselect;
         if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", rsp_valid, 0);
            end else begin
               sb_t e;
               e = sb.pop_front();
               check("rsp_idx", rsp_valid, N'(1) << e.idx);
               if (e.rd) begin
                  check("rsp_rdata", rsp_readdata, e.data);
                  last_rd <= e.data;
               end else begin
                  check("rsp_wr_hold", rsp_readdata, last_rd);
               end
            end
         end
      end
   end

   task automatic wait_ready(input int idx, output bit got);
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (req_ready[idx]) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic set_req(input int idx, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd);
      req_write[idx]               = wr;
      req_address[idx*AW +: AW]    = addr;
      req_writedata[idx*DW +: DW]  = wd;
   endtask

   // abort: 0 = complete, 1 = reset in accept cycle, 2 = reset in bus cycle.
   task automatic do_req(input int idx, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                         input int abort);
      bit got;
      set_req(idx, wr, addr, wd);
      req_valid[idx] = 1'b1;
      wait_ready(idx, got);
      check("accept", got, 1);
      req_valid[idx] = 1'b0;
      if (!got) return;
      check("ready_onehot", req_ready, N'(1) << idx);
      if (abort == 0) sb.push_back('{idx: idx, rd: !wr, data: exp_rd});
      if (abort != 1) begin
         @(negedge clk);
         check("issue_cs", pio_chipselect, 1);
         check("issue_bus", {pio_write_n, pio_address, pio_writedata}, {~wr, addr, wd});
      end
      if (abort != 0) begin
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         check("abort_cs", pio_chipselect, 0);
         check("abort_ready", req_ready, 0);
         for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("abort_quiet", {rsp_valid, pio_chipselect}, 0);
         end
         return;
      end
      @(negedge clk);
      check("rsp_at_a2", rsp_valid, wr ? (N'(1) << idx) : N'(0));
      if (!wr) begin
         @(negedge clk);
         check("rsp_at_a3", rsp_valid, N'(1) << idx);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cs_start, exp, last, cyc, grants;
      bit prev_wr, got;

      reset         = 1'b1;
      req_valid     = '0;
      req_write     = '0;
      req_address   = '0;
      req_writedata = '0;
`ifdef PIO_ARB_LOCK_EN
      req_lock      = '0;
`endif
      repeat (3) @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_rsp", rsp_valid, 0);
      check("rst_rdata", rsp_readdata, 0);
      check("rst_bus", {pio_chipselect, pio_write_n, pio_address, pio_writedata},
            {1'b0, 1'b1, 3'b0, 32'b0});
      reset = 1'b0;
      @(negedge clk);

      do_req(1, 1'b1, PIO_REG_DIR, 32'hFF, '0, 0);
      do_req(2, 1'b0, PIO_REG_DATA, '0, 32'hA5, 0);
      do_req(3, 1'b1, 3'd7, 32'h55, '0, 0);
      do_req(0, 1'b0, 3'd6, '0, '0, 0);

      cs_start = cs_pulses;
      do_req(0, 1'b1, PIO_REG_SET, 32'h0F, '0, 0);
      do_req(0, 1'b1, PIO_REG_CLR, 32'h03, '0, 0);
      check("setclr_data", pio_data, 32'h0C);
      check("setclr_pulses", cs_pulses - cs_start, 2);

      do_req(3, 1'b0, PIO_REG_DIR, '0, '0, 1);
      do_req(2, 1'b0, PIO_REG_DATA, '0, '0, 2);

      // All requesters pending: even ones write data, odd ones read dir.
      for (int i = 0; i < N; i++)
         set_req(i, (i % 2) == 0, (i % 2) == 0 ? PIO_REG_DATA : PIO_REG_DIR, 32'h10 + i);
      req_valid = '1;
      exp = 0; last = -1; cyc = 0; grants = 0; prev_wr = 1'b0;
      while (grants < 20 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (req_ready != '0) begin
            check("rr_order", req_ready, N'(1) << exp);
            if (last >= 0) check("rr_spacing", cyc - last, prev_wr ? 3 : 4);
            sb.push_back('{idx: exp, rd: (exp % 2) == 1, data: 32'hFF});
            prev_wr = (exp % 2) == 0;
            last    = cyc;
            exp     = (exp + 1) % N;
            grants++;
         end
      end
      req_valid = '0;
      check("rr_grants", grants, 20);
      repeat (6) @(negedge clk);

`ifdef PIO_ARB_LOCK_EN
      set_req(3, 1'b0, PIO_REG_DIR, '0);
      req_lock[3]  = 1'b1;
      req_valid[3] = 1'b1;
      wait_ready(3, got);
      check("lock_accept", got, 1);
      sb.push_back('{idx: 3, rd: 1'b1, data: 32'hFF});
      req_valid[3] = 1'b0;
      req_lock[3]  = 1'b0;
      set_req(0, 1'b1, PIO_REG_DATA, 32'h11);
      req_valid[0] = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         check("lock_hold", req_ready[0], 0);
      end
      set_req(3, 1'b1, PIO_REG_DIR, 32'hFF);
      req_valid[3] = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (req_ready != '0) got = 1'b1;
      end
      check("lock_owner", req_ready, 4'b1000);
      sb.push_back('{idx: 3, rd: 1'b0, data: '0});
      req_valid[3] = 1'b0;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (req_ready[0]) got = 1'b1;
      end
      check("unlock_gap", cyc, 3);
      sb.push_back('{idx: 0, rd: 1'b0, data: '0});
      req_valid[0] = 1'b0;
      repeat (6) @(negedge clk);
`endif

      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
